mem_word_sequencer: RTL
=======================

// Module: mem_word_sequencer
// PURPOSE
//   Initiator side of the byte-wide data memory (8-bit data, 13-bit address,
//   combinational read, clocked write). Turns one multi-byte load/store request
//   from the multicycle CPU control path into BYTES consecutive single-byte
//   accesses, little-endian. It assembles loaded bytes into a word and reports
//   completion with a one-cycle done pulse.
// PARAMETERS
//   ADDR_W  13  memory address width; byte addresses wrap modulo 2**ADDR_W
//   BYTES   4   bytes per request; word width is 8*BYTES
// PORTS
//   clk          in   1         clock; all state updates on rising edge
//   rst          in   1         synchronous, active-high reset
//   start        in   1         request strobe; sampled only when accepting
//   we           in   1         1 = store, 0 = load; latched on accept
//   addr         in   ADDR_W    base byte address; latched on accept
//   wdata        in   8*BYTES   store word; latched on accept
//   rdata        out  8*BYTES   assembled load word
//   busy         out  1         high while sequencing byte accesses
//   done         out  1         one-cycle completion pulse
//   mem_addr     out  ADDR_W    byte address to memory
//   mem_wdata    out  8         byte to memory
//   mem_writeEn  out  1         memory write enable
//   mem_rdata    in   8         combinational read byte from memory
// BEHAVIOUR
// - States: IDLE, ACCESS, DONE. Byte counter cnt spans 0..BYTES-1.
// - Reset (rst=1 at an edge): state<=IDLE, cnt<=0, rdata<=0, done=0, busy=0.
//   Internal address, we and wdata latches are also cleared to 0.
//   mem_writeEn is forced 0 combinationally while rst=1, including mid-ACCESS.
//   Reset mid-operation aborts the request. Bytes already written stay
//   written. rdata is cleared.
// - Accept: start=1 in IDLE or DONE latches addr/we/wdata, cnt<=0 -> ACCESS.
//   start in ACCESS is ignored; it is not queued.
// - ACCESS lasts exactly BYTES cycles. Each cycle, mem_addr = (base+cnt)
//   truncated to ADDR_W bits, so the sequence wraps 8191 -> 0.
//   - Store: mem_writeEn=1, mem_wdata = wdata[8*cnt +: 8].
//   - Load: mem_writeEn=0; the edge ending the cycle stores
//     rdata[8*cnt +: 8] <= mem_rdata.
//   - At cnt==BYTES-1 -> DONE; otherwise cnt<=cnt+1.
// - DONE lasts one cycle with done=1. Next state is ACCESS if start=1,
//   otherwise IDLE. Back-to-back requests therefore cost BYTES+1 cycles each.
// - Latency: start accepted at edge E0; byte accesses occupy cycles 1..BYTES;
//   done is high in cycle BYTES+1. For a load, rdata is valid in the done
//   cycle and holds until the next load writes its first byte.
//   Stores never modify rdata.
// - busy = (state==ACCESS). done = (state==DONE). mem_writeEn = we & busy & !rst.
// - Outside ACCESS: mem_addr = latched base, mem_wdata = 0, mem_writeEn = 0.
// - Memory-side outputs are combinational from registered state only.
//   There is no path from start to mem_*.
// TESTING
// 1 Reset: hold rst 2 cycles -> rdata=0, busy=0, done=0, mem_writeEn=0.
// 2 Store: addr=0x010, wdata=0xDEADBEEF -> bytes EF,BE,AD,DE written at
//   0x010..0x013 in cycles 1..4, done in cycle 5.
// 3 Load: same address -> rdata=0xDEADBEEF in done cycle; mem_writeEn=0 throughout.
// 4 Wrap: store 0x11223344 at 0x1FFE -> 44@1FFE, 33@1FFF, 22@0000, 11@0001.
//   A subsequent load from 0x1FFE returns 0x11223344.
// 5 Back-to-back and ignored start: hold start=1 continuously -> new request
//   accepted in the done cycle. start pulses during ACCESS do not restart cnt.
// 6 Reset mid-store after 2 bytes -> only those 2 bytes change.
//   mem_writeEn=0 in the rst cycle; state returns to IDLE; no done pulse.

Source files
------------

// File: rtl/mem_word_sequencer.sv
// Byte-serial initiator for a byte-wide data memory: one BYTES-wide load or
// store becomes BYTES consecutive little-endian single-byte accesses.
module mem_word_sequencer #(
  parameter int ADDR_W = 13,
  parameter int BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [8*BYTES-1:0]   wdata,
  output logic [8*BYTES-1:0]   rdata,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_writeEn,
  input  logic [7:0]           mem_rdata
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   base_r;
  logic                we_r;
  logic [8*BYTES-1:0]  wdata_r;
  logic [8*BYTES-1:0]  rdata_r;
  logic                busy_s;

  // Request acceptance, byte sequencing and little-endian load assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      base_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {(8*BYTES){1'b0}};
      rdata_r <= {(8*BYTES){1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r <= S_ACCESS;
            cnt_r   <= {CNT_W{1'b0}};
            base_r  <= addr;
            we_r    <= we;
            wdata_r <= wdata;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (!we_r) begin
            rdata_r[{cnt_r, 3'b000} +: 8] <= mem_rdata;
          end
          if (cnt_r == CNT_LAST) begin
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_s = (state_r == S_ACCESS);
  assign busy   = busy_s;
  assign done   = (state_r == S_DONE);
  assign rdata  = rdata_r;

  // Memory-side drive depends only on registered state; reset kills the write strobe at once.
  always_comb begin
    mem_addr    = base_r;
    mem_wdata   = 8'd0;
    mem_writeEn = 1'b0;
    if (busy_s) begin
      mem_addr    = base_r + ADDR_W'(cnt_r);
      mem_wdata   = wdata_r[{cnt_r, 3'b000} +: 8];
      mem_writeEn = we_r & ~rst;
    end else begin
      mem_addr    = base_r;
      mem_wdata   = 8'd0;
      mem_writeEn = 1'b0;
    end
  end

endmodule
